// File: rtl/pwm_mon_pkg.sv
// pwm_mon_pkg: mode codes and leg classes shared
// by the gate-drive read-back monitor.
package pwm_mon_pkg;

  localparam logic [1:0] MODE_OFF        = 2'b00;
  localparam logic [1:0] MODE_BUCK       = 2'b01;
  localparam logic [1:0] MODE_BOOST      = 2'b10;
  localparam logic [1:0] MODE_BUCK_BOOST = 2'b11;

  typedef enum logic [2:0] {
    CLS_OFF,
    CLS_PARK_HI,
    CLS_PARK_LO,
    CLS_SWITCH,
    CLS_ILLEGAL
  } leg_cls_e;

  // seen[i] is set once the pattern {L,H} == i was sampled
  function automatic leg_cls_e leg_class(
    input logic [3:0] seen
  );
    case (seen)
      4'b0001: leg_class = CLS_OFF;
      4'b0010: leg_class = CLS_PARK_HI;
      4'b0100: leg_class = CLS_PARK_LO;
      4'b0110: leg_class = CLS_SWITCH;
      default: leg_class = CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/pwm_gate_monitor_if.sv
// pwm_gate_monitor_if: gate-drive inputs and per-window
// measurement results of the gate monitor.
interface pwm_gate_monitor_if #(
  parameter int CNT_W = 8
);

  logic             gate_h1;
  logic             gate_l1;
  logic             gate_h2;
  logic             gate_l2;
  logic             fault_clr;
  logic             meas_valid;
  logic [1:0]       mode_out;
  logic             mode_ok;
  logic [CNT_W-1:0] duty_out;
  logic             fault_st;
  logic [1:0]       fault_leg;

  modport master (
    output gate_h1,
    output gate_l1,
    output gate_h2,
    output gate_l2,
    output fault_clr,
    input  meas_valid,
    input  mode_out,
    input  mode_ok,
    input  duty_out,
    input  fault_st,
    input  fault_leg
  );

  modport slave (
    input  gate_h1,
    input  gate_l1,
    input  gate_h2,
    input  gate_l2,
    input  fault_clr,
    output meas_valid,
    output mode_out,
    output mode_ok,
    output duty_out,
    output fault_st,
    output fault_leg
  );

endinterface

// File: rtl/pwm_leg_classifier.sv
// pwm_leg_classifier: synchronises one H-bridge leg and
// classifies its H/L patterns over one window.
module pwm_leg_classifier
  import pwm_mon_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic           sys_clk,
  input  logic           rst,
  input  logic           gate_h,
  input  logic           gate_l,
  input  logic           smp_en,
  input  logic           win_end,
  output leg_cls_e       cls,
  output logic [CNT_W:0] hi_cnt,
  output logic           st_now
);

  logic [SYNC_STAGES-1:0] h_sync;
  logic [SYNC_STAGES-1:0] l_sync;
  logic                   h_s;
  logic                   l_s;
  logic [3:0]             seen;
  logic [3:0]             seen_nx;
  logic [CNT_W:0]         hi_acc;

  assign h_s     = h_sync[SYNC_STAGES-1];
  assign l_s     = l_sync[SYNC_STAGES-1];
  assign st_now  = h_s & l_s;
  assign seen_nx = seen | (4'b0001 << {l_s, h_s});

  // window totals include the sample of the closing cycle
  assign cls    = leg_class(seen_nx);
  assign hi_cnt = hi_acc + {{CNT_W{1'b0}}, h_s};

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      h_sync <= '0;
      l_sync <= '0;
    end else begin
      h_sync[0] <= gate_h;
      l_sync[0] <= gate_l;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        h_sync[i] <= h_sync[i-1];
        l_sync[i] <= l_sync[i-1];
      end
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      seen   <= '0;
      hi_acc <= '0;
    end else if (smp_en) begin
      if (win_end) begin
        seen   <= '0;
        hi_acc <= '0;
      end else begin
        seen   <= seen_nx;
        hi_acc <= hi_cnt;
      end
    end
  end

endmodule

// File: rtl/pwm_gate_monitor.sv
// pwm_gate_monitor: per-window topology/duty read-back and
// sticky shoot-through flags. PWM_MON_AVG_EN adds 4-window averaging.
module pwm_gate_monitor
  import pwm_mon_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                sys_clk,
  input  logic                rst,
  pwm_gate_monitor_if.slave   bus
);

  localparam int PRE_W = $clog2(SYNC_STAGES + 1);
  localparam logic [PRE_W-1:0] PRE_LAST =
    PRE_W'(SYNC_STAGES - 1);
  localparam logic [CNT_W:0] WIN =
    {1'b1, {CNT_W{1'b0}}};

  logic [PRE_W-1:0] pre_cnt;
  logic             run;
  logic [CNT_W-1:0] wcnt;
  logic             win_end;

  leg_cls_e         cls1;
  leg_cls_e         cls2;
  logic [CNT_W:0]   hi1;
  logic [CNT_W:0]   hi2;
  logic             st1;
  logic             st2;

  logic             off_off;
  logic             is_buck;
  logic             is_boost;
  logic             is_bb;
  logic             dec_ok;
  logic [1:0]       dec_mode;
  logic [CNT_W:0]   dec_duty;
  logic [CNT_W-1:0] raw;
  logic [CNT_W-1:0] duty_new;

  logic             mv_q;
  logic [1:0]       mode_q;
  logic             ok_q;
  logic [CNT_W-1:0] duty_q;
  logic [1:0]       fault_q;
  logic             fault_st_q;
  logic [1:0]       fault_nx;

  // window starts once the synchronisers hold real samples
  assign win_end = run & (&wcnt);

  pwm_leg_classifier #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_leg1 (
    .sys_clk (sys_clk),
    .rst     (rst),
    .gate_h  (bus.gate_h1),
    .gate_l  (bus.gate_l1),
    .smp_en  (run),
    .win_end (win_end),
    .cls     (cls1),
    .hi_cnt  (hi1),
    .st_now  (st1)
  );

  pwm_leg_classifier #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_leg2 (
    .sys_clk (sys_clk),
    .rst     (rst),
    .gate_h  (bus.gate_h2),
    .gate_l  (bus.gate_l2),
    .smp_en  (run),
    .win_end (win_end),
    .cls     (cls2),
    .hi_cnt  (hi2),
    .st_now  (st2)
  );

  assign off_off  = (cls1 == CLS_OFF) &&
                    (cls2 == CLS_OFF);
  assign is_buck  = (cls1 == CLS_SWITCH ||
                     cls1 == CLS_PARK_LO) &&
                    (cls2 == CLS_PARK_HI);
  assign is_boost = (cls1 == CLS_PARK_HI) &&
                    (cls2 == CLS_SWITCH ||
                     cls2 == CLS_PARK_HI);
  assign is_bb    = (cls1 == CLS_SWITCH) &&
                    (cls2 == CLS_SWITCH);

  always_comb begin
    dec_ok   = 1'b0;
    dec_mode = MODE_OFF;
    dec_duty = '0;
    unique case (1'b1)
      off_off: begin
        dec_ok = 1'b1;
      end
      is_buck: begin
        dec_ok   = 1'b1;
        dec_mode = MODE_BUCK;
        dec_duty = hi1;
      end
      is_boost: begin
        dec_ok   = 1'b1;
        dec_mode = MODE_BOOST;
        dec_duty = WIN - hi2;
      end
      is_bb: begin
        dec_ok   = 1'b1;
        dec_mode = MODE_BUCK_BOOST;
        dec_duty = hi1;
      end
      default: ;
    endcase
  end

  assign raw = dec_duty[CNT_W] ? '1
                               : dec_duty[CNT_W-1:0];

`ifdef PWM_MON_AVG_EN
  logic [2:0][CNT_W-1:0] hist;
  logic [1:0]            hist_n;
  logic [1:0]            hist_mode;
  logic                  keep;
  logic [CNT_W+1:0]      hist_sum;

  // three stored windows plus the closing one
  always_comb begin
    keep     = (hist_n != 2'd0) &&
               (hist_mode == dec_mode);
    hist_sum = {2'b00, raw} +
               {2'b00, hist[0]} +
               {2'b00, hist[1]} +
               {2'b00, hist[2]} +
               (CNT_W+2)'(2);
    duty_new = raw;
    if (keep && hist_n == 2'd3)
      duty_new = hist_sum[CNT_W+1:2];
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      hist      <= '0;
      hist_n    <= '0;
      hist_mode <= MODE_OFF;
    end else if (win_end) begin
      if (!dec_ok) begin
        hist_n <= '0;
      end else begin
        hist      <= {hist[1:0], raw};
        hist_mode <= dec_mode;
        if (!keep)
          hist_n <= 2'd1;
        else if (hist_n != 2'd3)
          hist_n <= hist_n + 2'd1;
      end
    end
  end
`else
  assign duty_new = raw;
`endif

  // a new fault outranks a simultaneous clear
  assign fault_nx = (fault_q & ~{2{bus.fault_clr}}) |
                    {st2, st1};

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      pre_cnt    <= '0;
      run        <= 1'b0;
      wcnt       <= '0;
      mv_q       <= 1'b0;
      mode_q     <= MODE_OFF;
      ok_q       <= 1'b0;
      duty_q     <= '0;
      fault_q    <= '0;
      fault_st_q <= 1'b0;
    end else begin
      if (!run) begin
        pre_cnt <= pre_cnt + 1'b1;
        if (pre_cnt == PRE_LAST)
          run <= 1'b1;
      end else begin
        wcnt <= wcnt + 1'b1;
      end
      mv_q <= win_end;
      if (win_end) begin
        ok_q <= dec_ok;
        if (dec_ok) begin
          mode_q <= dec_mode;
          duty_q <= duty_new;
        end
      end
      fault_q    <= fault_nx;
      fault_st_q <= |fault_nx;
    end
  end

  assign bus.meas_valid = mv_q;
  assign bus.mode_out   = mode_q;
  assign bus.mode_ok    = ok_q;
  assign bus.duty_out   = duty_q;
  assign bus.fault_st   = fault_st_q;
  assign bus.fault_leg  = fault_q;

endmodule
